// File: rtl/mc_main_fsm.sv
// Main control FSM of the multicycle ARM datapath: FETCH/DECODE/execute/writeback sequencing.
// Optional memory wait handshake and timeout enabled by defining MEM_WAIT_EN.
module mc_main_fsm #(
   parameter int WAIT_LIMIT = 15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [1:0] op,
   input  logic [5:0] funct,
   input  logic       mem_ready,
   output logic       ir_write,
   output logic       next_pc,
   output logic       branch,
   output logic       reg_w,
   output logic       mem_w,
   output logic       adr_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] result_src,
   output logic       alu_op,
   output logic       instr_done,
   output logic       undef,
   output logic       mem_timeout,
   output logic [3:0] dbg_state
);

   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_MEMADR   = 4'd2,
      S_MEMRD    = 4'd3,
      S_MEMWR    = 4'd4,
      S_MEMWB    = 4'd5,
      S_EXECUTER = 4'd6,
      S_EXECUTEI = 4'd7,
      S_ALUWB    = 4'd8,
      S_BRANCH   = 4'd9
   } state_e;

   state_e state_q, state_d;

   // mem_go: the current memory state may advance; wait_exp: it gives up and restarts.
   logic mem_go;
   logic wait_exp;
   logic unused_bits;

`ifdef MEM_WAIT_EN
   localparam int WW = (WAIT_LIMIT < 1) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [WW-1:0] WAIT_MAX = WW'(WAIT_LIMIT);

   logic [WW-1:0] wait_q;
   logic          mem_state;
   logic          wait_hold;

   assign mem_state = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
   assign mem_go    = mem_ready;
   assign wait_exp  = !mem_ready && (wait_q == WAIT_MAX);
   assign wait_hold = mem_state && !mem_go && !wait_exp;

   // Counter is zero on entry to every memory state because any non-hold cycle clears it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wait_q <= '0;
      end else if (wait_hold) begin
         wait_q <= wait_q + 1'b1;
      end else begin
         wait_q <= '0;
      end
   end

   assign unused_bits = ^funct[4:1];
`else
   assign mem_go      = 1'b1;
   assign wait_exp    = 1'b0;
   assign unused_bits = ^{funct[4:1], mem_ready, 1'(WAIT_LIMIT)};
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_FETCH;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d     = S_FETCH;
      ir_write    = 1'b0;
      next_pc     = 1'b0;
      branch      = 1'b0;
      reg_w       = 1'b0;
      mem_w       = 1'b0;
      adr_src     = 1'b0;
      alu_src_a   = 1'b0;
      alu_src_b   = 2'b00;
      result_src  = 2'b00;
      alu_op      = 1'b0;
      instr_done  = 1'b0;
      undef       = 1'b0;
      mem_timeout = 1'b0;

      case (state_q)
         S_FETCH: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            if (mem_go) begin
               ir_write = 1'b1;
               next_pc  = 1'b1;
               state_d  = S_DECODE;
            end else if (wait_exp) begin
               mem_timeout = 1'b1;
               state_d     = S_FETCH;
            end else begin
               state_d = S_FETCH;
            end
         end
         S_DECODE: begin
            alu_src_a  = 1'b1;
            alu_src_b  = 2'b10;
            result_src = 2'b10;
            case (op)
               2'b00:   state_d = funct[5] ? S_EXECUTEI : S_EXECUTER;
               2'b01:   state_d = S_MEMADR;
               2'b10:   state_d = S_BRANCH;
               default: begin
                  undef      = 1'b1;
                  instr_done = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_b = 2'b01;
            state_d   = funct[0] ? S_MEMRD : S_MEMWR;
         end
         S_MEMRD: begin
            adr_src = 1'b1;
            if (mem_go) begin
               state_d = S_MEMWB;
            end else if (wait_exp) begin
               mem_timeout = 1'b1;
               state_d     = S_FETCH;
            end else begin
               state_d = S_MEMRD;
            end
         end
         S_MEMWR: begin
            adr_src = 1'b1;
            mem_w   = 1'b1;
            if (mem_go) begin
               instr_done = 1'b1;
               state_d    = S_FETCH;
            end else if (wait_exp) begin
               mem_timeout = 1'b1;
               state_d     = S_FETCH;
            end else begin
               state_d = S_MEMWR;
            end
         end
         S_MEMWB: begin
            result_src = 2'b01;
            reg_w      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_EXECUTER: begin
            alu_op  = 1'b1;
            state_d = S_ALUWB;
         end
         S_EXECUTEI: begin
            alu_src_b = 2'b01;
            alu_op    = 1'b1;
            state_d   = S_ALUWB;
         end
         S_ALUWB: begin
            reg_w      = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_b  = 2'b01;
            result_src = 2'b10;
            branch     = 1'b1;
            instr_done = 1'b1;
            state_d    = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

   assign dbg_state = state_q;

endmodule

// File: tb/tb_mc_main_fsm.sv
// Bench for mc_main_fsm: directed instructions, a reset abort and random instruction mix
// against a per-instruction output-sequence model; MEM_WAIT_EN adds wait/timeout steps.
module tb_mc_main_fsm;

   logic       clk;
   logic       reset;
   logic [1:0] op;
   logic [5:0] funct;
   logic       mem_ready;
   logic       ir_write, next_pc, branch, reg_w, mem_w, adr_src, alu_src_a;
   logic [1:0] alu_src_b, result_src;
   logic       alu_op, instr_done, undef, mem_timeout;
   logic [3:0] dbg_state;

   int checks   = 0;
   int failures = 0;

   logic [14:0] exp_q[$];
   logic [14:0] obs;

   // Field order: ir_write next_pc branch reg_w mem_w adr_src alu_src_a alu_src_b result_src alu_op instr_done undef mem_timeout
   localparam logic [14:0] V_FETCH  = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] V_DECODE = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] V_UNDEF  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 2'b10, 1'b0, 1'b1, 1'b1, 1'b0};
   localparam logic [14:0] V_MEMADR = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] V_MEMRD  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] V_MEMWR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [14:0] V_MEMWB  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [14:0] V_EXECR  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] V_EXECI  = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0};
   localparam logic [14:0] V_ALUWB  = {1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam logic [14:0] V_BRANCH = {1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0};

   assign obs = {ir_write, next_pc, branch, reg_w, mem_w, adr_src, alu_src_a,
                 alu_src_b, result_src, alu_op, instr_done, undef, mem_timeout};

`ifdef MEM_WAIT_EN
   localparam int TB_WAIT_LIMIT = 3;
`else
   localparam int TB_WAIT_LIMIT = 15;
`endif

   mc_main_fsm #(.WAIT_LIMIT(TB_WAIT_LIMIT)) dut (
      .clk        (clk),
      .reset      (reset),
      .op         (op),
      .funct      (funct),
      .mem_ready  (mem_ready),
      .ir_write   (ir_write),
      .next_pc    (next_pc),
      .branch     (branch),
      .reg_w      (reg_w),
      .mem_w      (mem_w),
      .adr_src    (adr_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .result_src (result_src),
      .alu_op     (alu_op),
      .instr_done (instr_done),
      .undef      (undef),
      .mem_timeout(mem_timeout),
      .dbg_state  (dbg_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [14:0] o, input logic [14:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s obs=%h exp=%h", tag, o, e);
      end
   endtask

   // Per-cycle output phases of one instruction, from its class.
   task automatic build_exp(input logic [1:0] o, input logic [5:0] f);
      exp_q.push_back(V_FETCH);
      if (o == 2'b11) begin
         exp_q.push_back(V_UNDEF);
      end else begin
         exp_q.push_back(V_DECODE);
         if (o == 2'b00) begin
            exp_q.push_back(f[5] ? V_EXECI : V_EXECR);
            exp_q.push_back(V_ALUWB);
         end else if (o == 2'b01) begin
            exp_q.push_back(V_MEMADR);
            if (f[0]) begin
               exp_q.push_back(V_MEMRD);
               exp_q.push_back(V_MEMWB);
            end else begin
               exp_q.push_back(V_MEMWR);
            end
         end else begin
            exp_q.push_back(V_BRANCH);
         end
      end
   endtask

   // Entered in the cycle before FETCH; returns at the negedge of the instruction's last cycle.
   task automatic run_instr(input string name, input logic [1:0] o, input logic [5:0] f);
      int cyc;
      build_exp(o, f);
      cyc = 1;
      while (exp_q.size() > 0) begin
         @(negedge clk);
         if (cyc == 1) begin
            op    = o;
            funct = f;
         end
`ifndef MEM_WAIT_EN
         mem_ready = 1'($urandom);
`endif
         #1;
         check($sformatf("%s_c%0d", name, cyc), obs, exp_q.pop_front());
         cyc++;
      end
   endtask

   initial begin
      reset     = 1'b1;
      op        = 2'b00;
      funct     = 6'd0;
      mem_ready = 1'b1;

      repeat (2) @(negedge clk);
      check("reset_fetch", obs, V_FETCH);
      op    = 2'b11;
      funct = 6'b111111;
      #1;
      check("reset_fetch_op11", obs, V_FETCH);
      @(posedge clk);
      #1 reset = 1'b0;

      run_instr("ldr",   2'b01, 6'b000001);
      run_instr("str",   2'b01, 6'b000000);
      run_instr("addi",  2'b00, 6'b101000);
      run_instr("addr",  2'b00, 6'b001000);
      run_instr("b",     2'b10, 6'b010101);
      run_instr("undef", 2'b11, 6'b000000);
      run_instr("after", 2'b00, 6'b100001);

      // LDR aborted by reset while in MEMRD.
      @(negedge clk);
      op    = 2'b01;
      funct = 6'b000001;
      check("abort_fetch", obs, V_FETCH);
      @(negedge clk);
      check("abort_decode", obs, V_DECODE);
      @(negedge clk);
      check("abort_memadr", obs, V_MEMADR);
      @(negedge clk);
      check("abort_memrd", obs, V_MEMRD);
      reset = 1'b1;
      #1;
      check("abort_in_reset", obs, V_FETCH);
      @(posedge clk);
      #1 reset = 1'b0;
      run_instr("post_abort", 2'b00, 6'b000000);

      for (int n = 0; n < 40; n++) begin
         run_instr($sformatf("rnd%0d", n), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
      end

`ifdef MEM_WAIT_EN
      run_instr("pre_wait", 2'b10, 6'd0);
      @(posedge clk);
      #1 mem_ready = 1'b0;
      @(negedge clk);
      check("wait_a_c1", {14'd0, ir_write}, 15'd0);
      @(negedge clk);
      check("wait_a_c2", {14'd0, ir_write}, 15'd0);
      @(posedge clk);
      #1 mem_ready = 1'b1;
      @(negedge clk);
      check("wait_a_c3", {14'd0, ir_write}, 15'd1);
      @(negedge clk);
      check("wait_a_decode", obs, V_DECODE);
      @(negedge clk);
      check("wait_a_branch", obs, V_BRANCH);
      @(posedge clk);
      #1 mem_ready = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         @(negedge clk);
         check($sformatf("wait_b_to_c%0d", i), {14'd0, mem_timeout}, {14'd0, 1'(i == 4)});
         check($sformatf("wait_b_ir_c%0d", i), {14'd0, ir_write}, 15'd0);
      end
      @(negedge clk);
      check("wait_b_refetch", {13'd0, mem_timeout, instr_done}, 15'd0);
      mem_ready = 1'b1;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
